// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the programmable tick generator.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_BURST    = 1'b1;

  localparam int DEF_CNT_W   = 26;
  localparam int DEF_BURST_W = 8;
  localparam int DEF_TC      = 49_999_999;

endpackage

// File: rtl/tick_prescaler.sv
// Prescale counter: counts while enabled, wraps to 0 after reaching tc and
// flags that wrap combinationally. clr has priority over counting.
module tick_prescaler
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = en && (cnt == tc);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Programmable tick generator with periodic and counted-burst modes.
// Define TICK_GEN_SQW_EN to add the sqw square-wave output.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int unsigned DEFAULT_TC = DEF_TC,
  parameter int          BURST_W    = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               tc_load,
  input  logic [CNT_W-1:0]   tc_in,
`ifdef TICK_GEN_SQW_EN
  output logic               sqw,
`endif
  output logic               tick,
  output logic               busy,
  output logic               done
);

  // Handshake: start/stop/tc_load are single-cycle strobes sampled on the
  // rising edge; pause is a level. tick/done are one-cycle registered strobes.

  state_t             state, state_n;
  logic [BURST_W-1:0] bcnt, bcnt_n;
  logic [BURST_W-1:0] len_r;
  logic [CNT_W-1:0]   tc_r;
  logic               mode_r;
  logic               tick_n, done_n;
  logic               active, clr, en, wrap;

  assign active = (state != IDLE);
  // Any restart of phase clears the prescaler and suppresses its wrap.
  assign clr    = stop || start || (tc_load && active);
  assign en     = active && !pause && !clr;

  tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .tc   (tc_r),
    .wrap (wrap)
  );

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      bcnt_n  = '0;
    end else if (start) begin
      state_n = RUN;
      bcnt_n  = '0;
    end else if (active) begin
      state_n = pause ? PAUSED : RUN;
      if (wrap) begin
        tick_n = 1'b1;
        if (mode_r == MODE_BURST) begin
          if (bcnt == len_r - 1'b1) begin
            done_n  = 1'b1;
            state_n = IDLE;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bcnt   <= '0;
      tc_r   <= CNT_W'(DEFAULT_TC);
      mode_r <= MODE_PERIODIC;
      len_r  <= BURST_W'(1);
      tick   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      tick  <= tick_n;
      done  <= done_n;
      busy  <= (state_n != IDLE);
      if (tc_load) begin
        tc_r <= tc_in;
      end
      if (start && !stop) begin
        mode_r <= mode;
        len_r  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
      end
    end
  end

`ifdef TICK_GEN_SQW_EN
  always_ff @(posedge clk) begin
    if (rst || stop || start) begin
      sqw <= 1'b0;
    end else if (tick_n) begin
      sqw <= ~sqw;
    end
  end
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Testbench for tick_gen: directed vector table, hand-written corner
// sequences and randomized traffic against a countdown reference model.
module tb_tick_gen;

  localparam int CNT_W   = 26;
  localparam int BURST_W = 8;
  localparam int DEF_TC  = 6;

  logic               clk = 1'b0;
  logic               rst, start, stop, pause, mode, tc_load;
  logic [BURST_W-1:0] burst_len;
  logic [CNT_W-1:0]   tc_in;
  logic               tick, busy, done;
`ifdef TICK_GEN_SQW_EN
  logic               sqw;
`endif

  always #5 clk = ~clk;

  tick_gen #(.CNT_W(CNT_W), .DEFAULT_TC(DEF_TC), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .burst_len (burst_len),
    .tc_load   (tc_load),
    .tc_in     (tc_in),
`ifdef TICK_GEN_SQW_EN
    .sqw       (sqw),
`endif
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counts down the clocks remaining until the next tick.
  bit m_run, m_mode, m_tick, m_done, m_sqw;
  int m_rem, m_tc, m_len, m_issued;

  typedef struct {
    logic               start, stop, pause, mode;
    logic [BURST_W-1:0] blen;
    logic               tcl;
    logic [CNT_W-1:0]   tci;
    logic               etick, ebusy, edone;
  } vec_t;
  vec_t vecs[$];

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, s, sp, p, md, input logic [BURST_W-1:0] bl,
                            input logic tl, input logic [CNT_W-1:0] ti);
    int new_tc;
    if (r) begin
      m_run = 0; m_tc = DEF_TC; m_issued = 0; m_sqw = 0;
      m_tick = 0; m_done = 0; m_rem = 0; m_mode = 0; m_len = 1;
      return;
    end
    m_tick = 0;
    m_done = 0;
    new_tc = tl ? int'(ti) : m_tc;
    if (sp) begin
      m_run = 0;
      m_sqw = 0;
    end else if (s) begin
      m_run = 1; m_mode = md; m_len = (bl == 0) ? 1 : int'(bl);
      m_issued = 0; m_rem = new_tc + 1; m_sqw = 0;
    end else if (m_run) begin
      if (tl) begin
        m_rem = new_tc + 1;
      end else if (!p) begin
        m_rem--;
        if (m_rem == 0) begin
          m_tick = 1;
          m_sqw  = !m_sqw;
          m_rem  = m_tc + 1;
          if (m_mode) begin
            m_issued++;
            if (m_issued == m_len) begin
              m_done = 1;
              m_run  = 0;
            end
          end
        end
      end
    end
    m_tc = new_tc;
  endtask

  task automatic step(input logic r, s, sp, p, md, input logic [BURST_W-1:0] bl,
                      input logic tl, input logic [CNT_W-1:0] ti);
    rst = r; start = s; stop = sp; pause = p; mode = md;
    burst_len = bl; tc_load = tl; tc_in = ti;
    @(posedge clk);
    model_edge(r, s, sp, p, md, bl, tl, ti);
    #1;
    check1("tick", tick, m_tick);
    check1("busy", busy, m_run);
    check1("done", done, m_done);
`ifdef TICK_GEN_SQW_EN
    check1("sqw", sqw, m_sqw);
`endif
  endtask

  task automatic idle(input logic p);
    step(0, 0, 0, p, 0, 0, 0, 0);
  endtask

  // Steps idle until a tick; n is the number of edges taken, maxn+1 if none.
  task automatic wait_tick(input int maxn, output int n);
    n = maxn + 1;
    for (int i = 1; i <= maxn; i++) begin
      idle(0);
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic push(input logic s, sp, p, md, input logic [BURST_W-1:0] bl,
                      input logic tl, input logic [CNT_W-1:0] ti,
                      input logic et, eb, ed);
    vec_t v;
    v.start = s; v.stop = sp; v.pause = p; v.mode = md; v.blen = bl;
    v.tcl = tl; v.tci = ti; v.etick = et; v.ebusy = eb; v.edone = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int  n;
    logic cur_p;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check1("rst_tick", tick, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);

    // Periodic TC=3 loaded with start, then a 3-tick burst at TC=2.
    push(1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
    for (int k = 1; k <= 8; k++) push(0, 0, 0, 0, 0, 0, 0, (k % 4 == 0), 1, 0);
    push(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 1, 3, 1, 2, 0, 1, 0);
    for (int k = 1; k <= 9; k++) push(0, 0, 0, 0, 0, 0, 0, (k % 3 == 0), (k < 9), (k == 9));
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      step(0, vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].mode,
           vecs[i].blen, vecs[i].tcl, vecs[i].tci);
      check1("vec_tick", tick, vecs[i].etick);
      check1("vec_busy", busy, vecs[i].ebusy);
      check1("vec_done", done, vecs[i].edone);
    end

    // Pause for 5 cycles mid-period at TC=4.
    step(0, 1, 0, 0, 0, 0, 1, 4);
    wait_tick(20, n); check_int("pause_first", n, 5);
    idle(0); idle(0);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check1("pause_low", tick, 1'b0);
    end
    wait_tick(20, n); check_int("pause_resume", n, 3);
    wait_tick(20, n); check_int("pause_after", n, 5);

    // Stop exactly when cnt==TC, then start and stop together.
    idle(0); idle(0); idle(0); idle(0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check1("stop_tick", tick, 1'b0);
    check1("stop_busy", busy, 1'b0);
    for (int k = 0; k < 6; k++) idle(0);
    check1("stop_stays", tick, 1'b0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    check1("startstop_busy", busy, 1'b0);
    idle(0);
    check1("startstop_idle", busy, 1'b0);

    // burst_len=0 at TC=0: a single tick with done.
    step(0, 1, 0, 0, 1, 0, 1, 0);
    check1("b0_busy", busy, 1'b1);
    idle(0);
    check1("b0_tick", tick, 1'b1);
    check1("b0_done", done, 1'b1);
    check1("b0_idle", busy, 1'b0);
    idle(0);
    check1("b0_quiet", tick, 1'b0);

    // tc_load mid-run restarts the phase.
    step(0, 1, 0, 0, 0, 0, 1, 3);
    idle(0); idle(0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    wait_tick(20, n); check_int("tcl_first", n, 2);
    wait_tick(20, n); check_int("tcl_next", n, 2);

    // Reset in the middle of a burst, then run at the default TC.
    step(0, 1, 0, 0, 1, 5, 1, 2);
    for (int k = 0; k < 4; k++) idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check1("mrst_tick", tick, 1'b0);
    check1("mrst_busy", busy, 1'b0);
    check1("mrst_done", done, 1'b0);
`ifdef TICK_GEN_SQW_EN
    check1("mrst_sqw", sqw, 1'b0);
`endif
    step(0, 1, 0, 0, 0, 0, 0, 0);
    wait_tick(20, n); check_int("deftc_first", n, DEF_TC + 1);
    wait_tick(20, n); check_int("deftc_next", n, DEF_TC + 1);

    // Randomized traffic against the reference model.
    cur_p = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) cur_p = !cur_p;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2,
           cur_p,
           1'($urandom_range(0, 1)),
           BURST_W'($urandom_range(0, 4)),
           $urandom_range(0, 99) < 3,
           CNT_W'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
